// File: rtl/tmboc_acq_sched_if.sv
// tmboc_acq_sched_if: control/status bundle between acquisition control, the scheduler and the PRN generator/correlator.
interface tmboc_acq_sched_if #(
    parameter int ACC_WIDTH = 32,
    parameter int MAG_WIDTH = 24,
    parameter int DOPP_W    = 6,
    parameter int CODE_W    = 12,
    parameter int TIMEOUT_W = 20
);
    logic                 rx_start;
    logic [ACC_WIDTH-1:0] rx_fcw_base;
    logic [ACC_WIDTH-1:0] rx_fcw_step;
    logic [ACC_WIDTH-1:0] rx_phs_step;
    logic [DOPP_W-1:0]    rx_num_dopp;
    logic [CODE_W-1:0]    rx_num_code;
    logic [TIMEOUT_W-1:0] rx_timeout;
    logic                 rx_prn_eop;
    logic                 rx_corr_valid;
    logic [MAG_WIDTH-1:0] rx_corr_mag;
    logic                 tx_gen_rst;
    logic [ACC_WIDTH-1:0] tx_prn_fcw;
    logic [ACC_WIDTH-1:0] tx_init_phs;
    logic                 tx_busy;
    logic                 tx_done;
    logic                 tx_err;
    logic [MAG_WIDTH-1:0] tx_best_mag;
    logic [DOPP_W-1:0]    tx_best_dopp;
    logic [CODE_W-1:0]    tx_best_code;

    modport master (
        output rx_start, rx_fcw_base, rx_fcw_step, rx_phs_step, rx_num_dopp, rx_num_code, rx_timeout,
               rx_prn_eop, rx_corr_valid, rx_corr_mag,
        input  tx_gen_rst, tx_prn_fcw, tx_init_phs, tx_busy, tx_done, tx_err, tx_best_mag, tx_best_dopp, tx_best_code
    );

    modport slave (
        input  rx_start, rx_fcw_base, rx_fcw_step, rx_phs_step, rx_num_dopp, rx_num_code, rx_timeout,
               rx_prn_eop, rx_corr_valid, rx_corr_mag,
        output tx_gen_rst, tx_prn_fcw, tx_init_phs, tx_busy, tx_done, tx_err, tx_best_mag, tx_best_dopp, tx_best_code
    );
endinterface

// File: rtl/tmboc_acq_sched.sv
// tmboc_acq_sched: steps the Doppler x code-offset grid, runs the PRN generator one period per cell
// and keeps the earliest strongest correlator magnitude.
module tmboc_acq_sched #(
    parameter int ACC_WIDTH = 32,
    parameter int MAG_WIDTH = 24,
    parameter int DOPP_W    = 6,
    parameter int CODE_W    = 12,
    parameter int TIMEOUT_W = 20
) (
    input logic              rx_clk,
    input logic              rx_rst,
    tmboc_acq_sched_if.slave bus
);
    typedef enum logic [2:0] {IDLE, LOAD, RUN, WAITC, NEXT, DONE} state_t;

    state_t               state, state_nxt;
    logic                 load_cnt;
    logic [TIMEOUT_W-1:0] wd, timeout;
    logic [DOPP_W-1:0]    dopp, dopp_last, best_dopp;
    logic [CODE_W-1:0]    code, code_last, best_code;
    logic [ACC_WIDTH-1:0] fcw, phs, fcw_step, phs_step;
    logic [MAG_WIDTH-1:0] best_mag;
    logic                 err, start_ok, code_wrap, last_cell, wd_fire, hit;

    always_comb begin
        state_nxt = state;
        start_ok  = (state == IDLE) && bus.rx_start;
        code_wrap = code == code_last;
        last_cell = code_wrap && (dopp == dopp_last);
        wd_fire   = wd == timeout;
        hit       = bus.rx_corr_valid && (bus.rx_corr_mag > best_mag);
        case (state)
            IDLE:    state_nxt = bus.rx_start ? LOAD : IDLE;
            LOAD:    state_nxt = load_cnt ? RUN : LOAD;
            RUN:     state_nxt = bus.rx_prn_eop ? WAITC : (wd_fire ? DONE : RUN);
            WAITC:   state_nxt = bus.rx_corr_valid ? NEXT : WAITC;
            NEXT:    state_nxt = last_cell ? DONE : LOAD;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge rx_clk) begin
        if (rx_rst) begin
            load_cnt  <= 1'b0;
            wd        <= '0;
            timeout   <= '0;
            dopp      <= '0;
            dopp_last <= '0;
            code      <= '0;
            code_last <= '0;
            fcw       <= '0;
            phs       <= '0;
            fcw_step  <= '0;
            phs_step  <= '0;
            best_mag  <= '0;
            best_dopp <= '0;
            best_code <= '0;
            err       <= 1'b0;
        end else begin
            load_cnt <= (state == LOAD) ? ~load_cnt : 1'b0;
            wd       <= (state == RUN) ? wd + 1'b1 : '0;
            if (start_ok) begin
                // storing last index (count-1) makes a zero count behave as one
                dopp_last <= (bus.rx_num_dopp == '0) ? '0 : bus.rx_num_dopp - 1'b1;
                code_last <= (bus.rx_num_code == '0) ? '0 : bus.rx_num_code - 1'b1;
                timeout   <= bus.rx_timeout;
                fcw_step  <= bus.rx_fcw_step;
                phs_step  <= bus.rx_phs_step;
                fcw       <= bus.rx_fcw_base;
                phs       <= '0;
                dopp      <= '0;
                code      <= '0;
                best_mag  <= '0;
                best_dopp <= '0;
                best_code <= '0;
                err       <= 1'b0;
            end
            if (state == RUN && !bus.rx_prn_eop && wd_fire) err <= 1'b1;
            if (state == WAITC && hit) begin
                best_mag  <= bus.rx_corr_mag;
                best_dopp <= dopp;
                best_code <= code;
            end
            if (state == NEXT) begin
                code <= code_wrap ? '0 : code + 1'b1;
                phs  <= code_wrap ? '0 : phs + phs_step;
                if (code_wrap && dopp != dopp_last) begin
                    dopp <= dopp + 1'b1;
                    fcw  <= fcw + fcw_step;
                end
            end
        end
    end

    assign bus.tx_gen_rst   = state != RUN;
    assign bus.tx_busy      = (state != IDLE) && (state != DONE);
    assign bus.tx_done      = state == DONE;
    assign bus.tx_prn_fcw   = fcw;
    assign bus.tx_init_phs  = phs;
    assign bus.tx_err       = err;
    assign bus.tx_best_mag  = best_mag;
    assign bus.tx_best_dopp = best_dopp;
    assign bus.tx_best_code = best_code;
endmodule

// File: tb/tb_tmboc_acq_sched.sv
// tb_tmboc_acq_sched: drives the scheduler as generator + correlator and checks cells, peaks and timing
// against a grid model built from base/step arithmetic.
module tb_tmboc_acq_sched;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0, bad = 0;
    logic [23:0] mags[$];
    int eops[$], cdly[$], obs_gap[$];
    logic [31:0] obs_fcw[$], obs_phs[$];
    logic [31:0] cfg_base, cfg_fstep, cfg_pstep;
    int cfg_nd, cfg_nc, done_wait;
    logic [23:0] exp_mag;
    int exp_d, exp_c;

    always #5 clk = ~clk;

    tmboc_acq_sched_if bus ();
    tmboc_acq_sched dut (.rx_clk(clk), .rx_rst(rst), .bus(bus));

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ncode();
        return cfg_nc == 0 ? 1 : cfg_nc;
    endfunction

    function automatic int ncells();
        return (cfg_nd == 0 ? 1 : cfg_nd) * ncode();
    endfunction

    function automatic logic [31:0] exp_fcw(input int i);
        return cfg_base + cfg_fstep * 32'(i / ncode());
    endfunction

    function automatic logic [31:0] exp_phs(input int i);
        return cfg_pstep * 32'(i % ncode());
    endfunction

    function automatic void model_best(input int n);
        exp_mag = 0;
        exp_d = 0;
        exp_c = 0;
        for (int i = 0; i < n; i++)
            if (mags[i] > exp_mag) begin
                exp_mag = mags[i];
                exp_d = i / ncode();
                exp_c = i % ncode();
            end
    endfunction

    task automatic fill(input int n, input int mag_hi, input int eop_hi);
        mags.delete();
        eops.delete();
        cdly.delete();
        for (int i = 0; i < n; i++) begin
            mags.push_back(24'($urandom_range(0, mag_hi)));
            eops.push_back($urandom_range(0, eop_hi));
            cdly.push_back($urandom_range(0, 3));
        end
    endtask

    task automatic start_search(input logic [31:0] base, fstep, pstep, input int nd, nc, tmo);
        cfg_base = base;
        cfg_fstep = fstep;
        cfg_pstep = pstep;
        cfg_nd = nd;
        cfg_nc = nc;
        obs_fcw.delete();
        obs_phs.delete();
        obs_gap.delete();
        bus.rx_fcw_base = base;
        bus.rx_fcw_step = fstep;
        bus.rx_phs_step = pstep;
        bus.rx_num_dopp = 6'(nd);
        bus.rx_num_code = 12'(nc);
        bus.rx_timeout = 20'(tmo);
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
    endtask

    // Plays generator and correlator for n cells; extras injects a stray start and correlator strobe in cell 0's RUN.
    task automatic serve_cells(input int n, input bit extras);
        for (int i = 0; i < n; i++) begin
            int gap = 0;
            while (bus.tx_gen_rst && gap < 20) begin
                tick();
                gap++;
            end
            obs_gap.push_back(gap);
            obs_fcw.push_back(bus.tx_prn_fcw);
            obs_phs.push_back(bus.tx_init_phs);
            for (int k = 0; k < eops[i]; k++) begin
                if (extras && i == 0 && k == 0) begin
                    bus.rx_corr_valid = 1'b1;
                    bus.rx_corr_mag = '1;
                    bus.rx_start = 1'b1;
                    bus.rx_fcw_base = 32'h1234_5678;
                end
                tick();
                bus.rx_corr_valid = 1'b0;
                bus.rx_start = 1'b0;
                bus.rx_fcw_base = cfg_base;
            end
            bus.rx_prn_eop = 1'b1;
            tick();
            bus.rx_prn_eop = 1'b0;
            for (int k = 0; k < cdly[i]; k++) tick();
            bus.rx_corr_mag = mags[i];
            bus.rx_corr_valid = 1'b1;
            tick();
            bus.rx_corr_valid = 1'b0;
        end
    endtask

    task automatic wait_done();
        done_wait = 0;
        while (!bus.tx_done && done_wait < 200) begin
            tick();
            done_wait++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        total += 4;
        if (bus.tx_gen_rst !== 1'b1) begin bad++; $display("FAIL reset_gen_rst: got %b want 1", bus.tx_gen_rst); end
        if ({bus.tx_busy, bus.tx_done, bus.tx_err} !== 3'b000) begin
            bad++; $display("FAIL reset_flags: got %b want 000", {bus.tx_busy, bus.tx_done, bus.tx_err});
        end
        if ({bus.tx_prn_fcw, bus.tx_init_phs} !== 64'd0) begin
            bad++; $display("FAIL reset_words: got %h want 0", {bus.tx_prn_fcw, bus.tx_init_phs});
        end
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== 42'd0) begin
            bad++; $display("FAIL reset_best: got %h want 0", {bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        mags = '{24'd50};
        eops = '{100};
        cdly = '{2};
        start_search(32'h1000_0000, 32'h0, 32'h0, 1, 1, 1000);
        total++;
        if (bus.tx_busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", bus.tx_busy); end
        serve_cells(1, 1'b0);
        wait_done();
        total += 6;
        if (obs_gap[0] != 2) begin bad++; $display("FAIL single_load_len: got %0d want 2", obs_gap[0]); end
        if (obs_fcw[0] !== 32'h1000_0000) begin bad++; $display("FAIL single_fcw: got %h want 10000000", obs_fcw[0]); end
        if (done_wait != 1) begin bad++; $display("FAIL single_done_lat: got %0d want 1", done_wait); end
        if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL single_busy_done: got %b want 0", bus.tx_busy); end
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== {24'd50, 6'd0, 12'd0}) begin
            bad++; $display("FAIL single_best: got %0d/%0d/%0d want 50/0/0", bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code);
        end
        if (bus.tx_err !== 1'b0) begin bad++; $display("FAIL single_err: got %b want 0", bus.tx_err); end
        bus.rx_start = 1'b1;
        tick();
        bus.rx_start = 1'b0;
        total += 2;
        if ({bus.tx_busy, bus.tx_done} !== 2'b00) begin
            bad++; $display("FAIL single_start_on_done: got busy,done=%b want 00", {bus.tx_busy, bus.tx_done});
        end
        if (bus.tx_gen_rst !== 1'b1) begin bad++; $display("FAIL single_gen_rst_idle: got %b want 1", bus.tx_gen_rst); end
        tick();
    endtask

    task automatic test_grid();
        fill(12, 0, 5);
        for (int i = 0; i < 12; i++) mags[i] = (i == 9) ? 24'd900 : 24'd10;
        start_search(32'h0400_0000, 32'h0001_0000, 32'h0000_3000, 3, 4, 1000);
        serve_cells(12, 1'b0);
        wait_done();
        for (int i = 0; i < 12; i++) begin
            total += 3;
            if (obs_fcw[i] !== exp_fcw(i)) begin bad++; $display("FAIL grid_fcw[%0d]: got %h want %h", i, obs_fcw[i], exp_fcw(i)); end
            if (obs_phs[i] !== exp_phs(i)) begin bad++; $display("FAIL grid_phs[%0d]: got %h want %h", i, obs_phs[i], exp_phs(i)); end
            if (obs_gap[i] != (i == 0 ? 2 : 3)) begin bad++; $display("FAIL grid_gap[%0d]: got %0d want %0d", i, obs_gap[i], i == 0 ? 2 : 3); end
        end
        total += 3;
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== {24'd900, 6'd2, 12'd1}) begin
            bad++; $display("FAIL grid_best: got %0d/%0d/%0d want 900/2/1", bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code);
        end
        if (obs_fcw[9] !== 32'h0402_0000 || obs_phs[9] !== 32'h0000_3000) begin
            bad++; $display("FAIL grid_peak_cell: got fcw=%h phs=%h want 04020000/00003000", obs_fcw[9], obs_phs[9]);
        end
        if (done_wait != 1) begin bad++; $display("FAIL grid_done_lat: got %0d want 1", done_wait); end
        tick();
    endtask

    task automatic test_tie();
        fill(6, 0, 3);
        for (int i = 0; i < 6; i++) mags[i] = (i == 2 || i == 3) ? 24'd77 : 24'd5;
        start_search(32'h0, 32'h10, 32'h1, 2, 3, 1000);
        serve_cells(6, 1'b0);
        wait_done();
        total++;
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== {24'd77, 6'd0, 12'd2}) begin
            bad++; $display("FAIL tie_best: got %0d/%0d/%0d want 77/0/2", bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code);
        end
        tick();
    endtask

    task automatic test_timeout();
        int g = 0, t = 0;
        mags = '{24'd300, 24'd999, 24'd999};
        eops = '{4, 0, 0};
        cdly = '{1, 0, 0};
        start_search(32'h100, 32'h0, 32'h40, 1, 3, 50);
        serve_cells(1, 1'b0);
        while (bus.tx_gen_rst && g < 20) begin tick(); g++; end
        while (!bus.tx_done && t < 200) begin tick(); t++; end
        total += 4;
        if (t < 50 || t > 52) begin bad++; $display("FAIL timeout_latency: got %0d cycles in RUN want 50..52", t); end
        if (bus.tx_err !== 1'b1) begin bad++; $display("FAIL timeout_err: got %b want 1", bus.tx_err); end
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== {24'd300, 6'd0, 12'd0}) begin
            bad++; $display("FAIL timeout_partial_best: got %0d/%0d/%0d want 300/0/0", bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code);
        end
        if (bus.tx_busy !== 1'b0) begin bad++; $display("FAIL timeout_busy: got %b want 0", bus.tx_busy); end
        tick();
        total += 2;
        if (bus.tx_gen_rst !== 1'b1) begin bad++; $display("FAIL timeout_gen_rst: got %b want 1", bus.tx_gen_rst); end
        if (bus.tx_err !== 1'b1) begin bad++; $display("FAIL timeout_err_held: got %b want 1", bus.tx_err); end
        mags = '{24'd7};
        eops = '{2};
        cdly = '{0};
        start_search(32'h0, 32'h0, 32'h0, 1, 1, 1000);
        total += 2;
        if (bus.tx_err !== 1'b0) begin bad++; $display("FAIL timeout_err_clear: got %b want 0", bus.tx_err); end
        if (bus.tx_best_mag !== 24'd0) begin bad++; $display("FAIL timeout_best_clear: got %0d want 0", bus.tx_best_mag); end
        serve_cells(1, 1'b0);
        wait_done();
        total++;
        if (bus.tx_best_mag !== 24'd7) begin bad++; $display("FAIL timeout_rerun_best: got %0d want 7", bus.tx_best_mag); end
        tick();
    endtask

    task automatic test_reset_mid();
        int g = 0, dn = 0;
        fill(8, 15, 4);
        mags[1] = 24'd200;
        start_search(32'h0200_0000, 32'h0000_0100, 32'h0000_0008, 2, 4, 1000);
        serve_cells(5, 1'b0);
        while (bus.tx_gen_rst && g < 20) begin tick(); g++; end
        total += 2;
        if (bus.tx_prn_fcw !== exp_fcw(5) || bus.tx_init_phs !== exp_phs(5)) begin
            bad++; $display("FAIL midrst_cell5: got %h/%h want %h/%h", bus.tx_prn_fcw, bus.tx_init_phs, exp_fcw(5), exp_phs(5));
        end
        if (bus.tx_best_mag !== 24'd200) begin bad++; $display("FAIL midrst_pre_best: got %0d want 200", bus.tx_best_mag); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total += 4;
        if ({bus.tx_busy, bus.tx_done, bus.tx_err, bus.tx_gen_rst} !== 4'b0001) begin
            bad++; $display("FAIL midrst_flags: got %b want 0001", {bus.tx_busy, bus.tx_done, bus.tx_err, bus.tx_gen_rst});
        end
        if ({bus.tx_prn_fcw, bus.tx_init_phs} !== 64'd0) begin
            bad++; $display("FAIL midrst_words: got %h want 0", {bus.tx_prn_fcw, bus.tx_init_phs});
        end
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== 42'd0) begin
            bad++; $display("FAIL midrst_best: got %h want 0", {bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code});
        end
        repeat (6) begin
            if (bus.tx_done) dn++;
            tick();
        end
        if (dn != 0) begin bad++; $display("FAIL midrst_no_done: got %0d done pulses want 0", dn); end
        fill(8, 15, 4);
        start_search(32'h0300_0000, 32'h0000_0200, 32'h0000_0010, 2, 4, 1000);
        serve_cells(8, 1'b0);
        wait_done();
        model_best(8);
        total += 3;
        if (obs_fcw[0] !== 32'h0300_0000 || obs_phs[0] !== 32'h0) begin
            bad++; $display("FAIL midrst_restart_cell0: got %h/%h want 03000000/0", obs_fcw[0], obs_phs[0]);
        end
        if (obs_fcw[7] !== exp_fcw(7) || obs_phs[7] !== exp_phs(7)) begin
            bad++; $display("FAIL midrst_restart_cell7: got %h/%h want %h/%h", obs_fcw[7], obs_phs[7], exp_fcw(7), exp_phs(7));
        end
        if ({bus.tx_best_mag, 32'(bus.tx_best_dopp), 32'(bus.tx_best_code)} !== {exp_mag, exp_d, exp_c}) begin
            bad++; $display("FAIL midrst_restart_best: got %0d/%0d/%0d want %0d/%0d/%0d",
                            bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code, exp_mag, exp_d, exp_c);
        end
        tick();
    endtask

    task automatic test_wrap();
        mags = '{24'd3, 24'd4};
        eops = '{3, 2};
        cdly = '{1, 1};
        start_search(32'hFFFF_FFF0, 32'h0000_0020, 32'h0, 2, 1, 1000);
        serve_cells(2, 1'b1);
        wait_done();
        total += 4;
        if (obs_fcw[0] !== 32'hFFFF_FFF0) begin bad++; $display("FAIL wrap_bin0: got %h want fffffff0", obs_fcw[0]); end
        if (obs_fcw[1] !== 32'h0000_0010) begin bad++; $display("FAIL wrap_bin1: got %h want 00000010", obs_fcw[1]); end
        if (done_wait != 1) begin bad++; $display("FAIL wrap_done_lat: got %0d want 1", done_wait); end
        if ({bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code} !== {24'd4, 6'd1, 12'd0}) begin
            bad++; $display("FAIL wrap_best_ignores_stray: got %0d/%0d/%0d want 4/1/0", bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code);
        end
        tick();
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            int n;
            start_search($urandom, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 4), 1000);
            n = ncells();
            fill(n, 12, 6);
            serve_cells(n, 1'b0);
            wait_done();
            model_best(n);
            for (int i = 0; i < n; i++) begin
                total += 2;
                if (obs_fcw[i] !== exp_fcw(i)) begin bad++; $display("FAIL rnd%0d_fcw[%0d]: got %h want %h", it, i, obs_fcw[i], exp_fcw(i)); end
                if (obs_phs[i] !== exp_phs(i)) begin bad++; $display("FAIL rnd%0d_phs[%0d]: got %h want %h", it, i, obs_phs[i], exp_phs(i)); end
            end
            total += 3;
            if (done_wait != 1) begin bad++; $display("FAIL rnd%0d_done_lat: got %0d want 1", it, done_wait); end
            if (bus.tx_err !== 1'b0) begin bad++; $display("FAIL rnd%0d_err: got %b want 0", it, bus.tx_err); end
            if ({bus.tx_best_mag, 32'(bus.tx_best_dopp), 32'(bus.tx_best_code)} !== {exp_mag, exp_d, exp_c}) begin
                bad++; $display("FAIL rnd%0d_best: got %0d/%0d/%0d want %0d/%0d/%0d", it,
                                bus.tx_best_mag, bus.tx_best_dopp, bus.tx_best_code, exp_mag, exp_d, exp_c);
            end
            tick();
        end
    endtask

    initial begin
        bus.rx_start = 1'b0;
        bus.rx_fcw_base = '0;
        bus.rx_fcw_step = '0;
        bus.rx_phs_step = '0;
        bus.rx_num_dopp = '0;
        bus.rx_num_code = '0;
        bus.rx_timeout = '0;
        bus.rx_prn_eop = 1'b0;
        bus.rx_corr_valid = 1'b0;
        bus.rx_corr_mag = '0;
        test_reset();
        test_single();
        test_grid();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
